key_entry: RTL and testbench
============================

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter MAX_DIGITS, default 8, maximum BCD digits per operand (1..8).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 key_code  input  4  key code from scanner (0-9 digits, 10-13 A-D, 14 '#', 15 '*'); updates in the same cycle as key_toggle.
REQ-005 key_toggle  input  2  scanner press indicator; bit0 toggles once per accepted key, bit1 ignored.
REQ-006 entry_bcd  output  32  operand being typed, packed BCD, least significant digit in bits [3:0].
REQ-007 digit_count  output  4  significant digits in entry_bcd.
REQ-008 operand_a  output  32  first operand, latched on an operator key.
REQ-009 operand_b  output  32  second operand, latched on '#'.
REQ-010 op_code  output  2  operator (A=0, B=1, C=2, D=3).
REQ-011 state  output  2  FSM state (ENTER_A=0, ENTER_B=1, DONE=2).
REQ-012 enter_pulse  output  1  one-cycle strobe when operand_b is latched.
REQ-013 overflow  output  1  sticky flag: digit rejected because entry was full.

Function
REQ-014 Key event = key_toggle[0] differs from its value registered on the previous cycle; key_code is registered with it; the event acts one clock after the toggle edge.
REQ-015 Digit 0-9, count < MAX_DIGITS: entry_bcd shifts left 4 bits, digit enters [3:0], count increments.
REQ-016 Digit 0 with count 0: entry_bcd stays 0, count stays 0 (no leading zeros).
REQ-017 Digit with count == MAX_DIGITS: entry and count unchanged, overflow set.
REQ-018 Operator A-D in ENTER_A: operand_a <= entry_bcd, op_code <= code-10, entry and count cleared, state -> ENTER_B.
REQ-019 Operator in ENTER_B: op_code replaced only; operand_a and entry unchanged.
REQ-020 Operator in DONE: ignored.
REQ-021 '#' in ENTER_B: operand_b <= entry_bcd, enter_pulse high one cycle, state -> DONE; entry and count retained.
REQ-022 '#' in ENTER_A or DONE: ignored, no pulse.
REQ-023 Digit in DONE: entry, count, operand_a, operand_b, op_code, overflow cleared, state -> ENTER_A, digit applied per REQ-015/016 in the same cycle.
REQ-024 '*' in any state: all outputs to reset values, state -> ENTER_A.
REQ-025 No key_toggle edge: all registers hold; enter_pulse low.
REQ-026 Operand arithmetic is BCD shift only; no binary conversion.

Reset
REQ-027 rst high: entry_bcd, digit_count, operand_a, operand_b, op_code, enter_pulse, overflow = 0; state = ENTER_A; toggle history register <= key_toggle[0] (no spurious event after reset).
REQ-028 rst wins over a coincident key event; that event is discarded.

Structure
REQ-029 Shared package keypad_pkg holds key-code constants (0..15), the state encoding, and the MAX_DIGITS default.
REQ-030 Toggle-edge detection plus key_code capture is a sub-module key_event_detect (outputs event strobe and registered code).

Verification
REQ-031 Keys 1,2,3 -> entry_bcd=0x00000123, digit_count=3, state=ENTER_A.
REQ-032 Keys 0,0,7 -> entry_bcd=0x7, digit_count=1.
REQ-033 Keys 4,5,B,6,# -> operand_a=0x45, op_code=1, operand_b=0x6, one enter_pulse, state=DONE.
REQ-034 Nine digits 1..9 -> entry_bcd=0x12345678, count=8, overflow=1; then '*' -> all zero, state=ENTER_A.
REQ-035 In DONE press 9 -> operand_a=0, operand_b=0, entry_bcd=0x9, state=ENTER_A; '#' in ENTER_A -> no pulse.
REQ-036 rst asserted in the same cycle as a key event after 2,A -> all outputs zero; event not applied.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, entry FSM encoding, default operand width
// and small helpers used by the key entry logic.
package keypad_pkg;

  localparam int MAX_DIGITS_DEFAULT = 8;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_STAR = 4'd15;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  typedef enum logic [1:0] {
    KEY_CLASS_DIGIT = 2'd0,
    KEY_CLASS_OP    = 2'd1,
    KEY_CLASS_HASH  = 2'd2,
    KEY_CLASS_STAR  = 2'd3
  } key_class_t;

  function automatic key_class_t classify_key(input logic [3:0] code);
    key_class_t cls;
    if (code <= KEY_9) begin
      cls = KEY_CLASS_DIGIT;
    end else if (code <= KEY_D) begin
      cls = KEY_CLASS_OP;
    end else if (code == KEY_HASH) begin
      cls = KEY_CLASS_HASH;
    end else begin
      cls = KEY_CLASS_STAR;
    end
    return cls;
  endfunction

  // Append one decimal digit at the least significant end of a packed BCD word.
  function automatic logic [31:0] bcd_push(input logic [31:0] bcd, input logic [3:0] digit);
    return {bcd[27:0], digit};
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns the scanner's toggle handshake into a one-cycle key event strobe,
// registering the key code alongside it.
module key_event_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_toggle,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] event_code
);

  logic toggle_hist;
  logic unused_toggle_bit;

  assign unused_toggle_bit = key_toggle[1];

  // Reset loads the current toggle level so no phantom event follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_hist <= key_toggle[0];
      key_event   <= 1'b0;
      event_code  <= 4'd0;
    end else begin
      toggle_hist <= key_toggle[0];
      key_event   <= key_toggle[0] ^ toggle_hist;
      event_code  <= key_code;
    end
  end

endmodule

// File: rtl/key_entry.sv
// Keypad operand entry: collects BCD digits into two operands separated by an
// operator key (A-D), closes with '#', clears with '*'.
module key_entry
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic [1:0]  key_toggle,
  output logic [31:0] entry_bcd,
  output logic [3:0]  digit_count,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [1:0]  op_code,
  output logic [1:0]  state,
  output logic        enter_pulse,
  output logic        overflow
);

  localparam logic [3:0] FULL_COUNT = 4'(MAX_DIGITS);

  logic         key_event;
  logic [3:0]   event_code;
  entry_state_t fsm_state;
  entry_state_t state_nxt;
  logic [31:0]  entry_nxt;
  logic [3:0]   count_nxt;
  logic [31:0]  a_nxt;
  logic [31:0]  b_nxt;
  logic [1:0]   op_nxt;
  logic         ovf_nxt;
  logic         pulse_nxt;
  logic [31:0]  base_entry;
  logic [3:0]   base_count;

  key_event_detect u_event (
    .clk        (clk),
    .rst        (rst),
    .key_toggle (key_toggle),
    .key_code   (key_code),
    .key_event  (key_event),
    .event_code (event_code)
  );

  assign state = fsm_state;

  // Next-state and next-output decode for one key event.
  always_comb begin
    entry_nxt  = entry_bcd;
    count_nxt  = digit_count;
    a_nxt      = operand_a;
    b_nxt      = operand_b;
    op_nxt     = op_code;
    ovf_nxt    = overflow;
    state_nxt  = fsm_state;
    pulse_nxt  = 1'b0;
    base_entry = entry_bcd;
    base_count = digit_count;
    if (key_event) begin
      case (classify_key(event_code))
        KEY_CLASS_STAR: begin
          entry_nxt = 32'd0;
          count_nxt = 4'd0;
          a_nxt     = 32'd0;
          b_nxt     = 32'd0;
          op_nxt    = 2'd0;
          ovf_nxt   = 1'b0;
          state_nxt = ENTER_A;
        end
        KEY_CLASS_DIGIT: begin
          // A digit after completion starts a fresh calculation with this digit.
          if (fsm_state == DONE) begin
            base_entry = 32'd0;
            base_count = 4'd0;
            a_nxt      = 32'd0;
            b_nxt      = 32'd0;
            op_nxt     = 2'd0;
            ovf_nxt    = 1'b0;
            state_nxt  = ENTER_A;
          end else begin
            base_entry = entry_bcd;
            base_count = digit_count;
          end
          if (base_count >= FULL_COUNT) begin
            entry_nxt = base_entry;
            count_nxt = base_count;
            ovf_nxt   = 1'b1;
          end else if ((base_count == 4'd0) && (event_code == KEY_0)) begin
            entry_nxt = 32'd0;
            count_nxt = 4'd0;
          end else begin
            entry_nxt = bcd_push(base_entry, event_code);
            count_nxt = base_count + 4'd1;
          end
        end
        KEY_CLASS_OP: begin
          case (fsm_state)
            ENTER_A: begin
              a_nxt     = entry_bcd;
              op_nxt    = 2'(event_code - KEY_A);
              entry_nxt = 32'd0;
              count_nxt = 4'd0;
              state_nxt = ENTER_B;
            end
            ENTER_B: begin
              op_nxt = 2'(event_code - KEY_A);
            end
            default: begin
              state_nxt = fsm_state;
            end
          endcase
        end
        KEY_CLASS_HASH: begin
          if (fsm_state == ENTER_B) begin
            b_nxt     = entry_bcd;
            pulse_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            pulse_nxt = 1'b0;
          end
        end
        default: begin
          pulse_nxt = 1'b0;
        end
      endcase
    end else begin
      pulse_nxt = 1'b0;
    end
  end

  // Output and state registers; reset discards any coincident key event.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_bcd   <= 32'd0;
      digit_count <= 4'd0;
      operand_a   <= 32'd0;
      operand_b   <= 32'd0;
      op_code     <= 2'd0;
      overflow    <= 1'b0;
      enter_pulse <= 1'b0;
      fsm_state   <= ENTER_A;
    end else begin
      entry_bcd   <= entry_nxt;
      digit_count <= count_nxt;
      operand_a   <= a_nxt;
      operand_b   <= b_nxt;
      op_code     <= op_nxt;
      overflow    <= ovf_nxt;
      enter_pulse <= pulse_nxt;
      fsm_state   <= state_nxt;
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed vector table, reset corner cases,
// and random key sequences against a decimal-arithmetic reference model.
module tb_key_entry;

  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic [1:0]  key_toggle;
  logic [31:0] entry_bcd;
  logic [3:0]  digit_count;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  op_code;
  logic [1:0]  state;
  logic        enter_pulse;
  logic        overflow;

  int checks = 0;
  int passed = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] entry;
    logic [3:0]  cnt;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        ovf;
    logic        pulse;
  } vec_t;

  vec_t vt[$];

  // reference model: operand being typed kept as a plain decimal number
  longint      m_val;
  int          m_cnt;
  int          m_st;
  int          m_op;
  logic        m_ovf;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          m_pulses;

  key_entry #(.MAX_DIGITS(MAXD)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_toggle  (key_toggle),
    .entry_bcd   (entry_bcd),
    .digit_count (digit_count),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_code     (op_code),
    .state       (state),
    .enter_pulse (enter_pulse),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enter_pulse) pulse_cnt++;
  end

  function automatic vec_t mk(input logic [3:0] key, input logic [31:0] entry, input logic [3:0] cnt,
                              input logic [1:0] st, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] op, input logic ovf, input logic pulse);
    vec_t v;
    v.key = key; v.entry = entry; v.cnt = cnt; v.st = st; v.a = a;
    v.b = b; v.op = op; v.ovf = ovf; v.pulse = pulse;
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint x;
    x = v;
    r = 32'd0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e, input logic [3:0] c, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic ovf, input logic pulse);
    chk({tag, ".entry"}, entry_bcd, e);
    chk({tag, ".count"}, {28'd0, digit_count}, {28'd0, c});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, s});
    chk({tag, ".opa"}, operand_a, a);
    chk({tag, ".opb"}, operand_b, b);
    chk({tag, ".op"}, {30'd0, op_code}, {30'd0, op});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ovf});
    chk({tag, ".pulse"}, {31'd0, enter_pulse}, {31'd0, pulse});
  endtask

  // Toggle the scanner handshake and wait until the key has taken effect.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code      = code;
    key_toggle[0] = ~key_toggle[0];
    key_toggle[1] = 1'($urandom_range(0, 1));
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_val = 0; m_cnt = 0; m_st = 0; m_op = 0; m_ovf = 1'b0; m_a = 32'd0; m_b = 32'd0;
  endtask

  task automatic model_key(input logic [3:0] c, output logic exp_pulse);
    exp_pulse = 1'b0;
    if (c == 4'd15) begin
      model_reset();
    end else if (c <= 4'd9) begin
      if (m_st == 2) model_reset();
      if (m_cnt == MAXD) m_ovf = 1'b1;
      else if (!(m_cnt == 0 && c == 4'd0)) begin
        m_val = m_val * 10 + longint'(c);
        m_cnt = m_cnt + 1;
      end
    end else if (c <= 4'd13) begin
      if (m_st == 0) begin
        m_a = to_bcd(m_val); m_op = int'(c) - 10; m_val = 0; m_cnt = 0; m_st = 1;
      end else if (m_st == 1) begin
        m_op = int'(c) - 10;
      end
    end else begin
      if (m_st == 1) begin
        m_b = to_bcd(m_val); m_st = 2; m_pulses++; exp_pulse = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] acc;
    logic        ep;
    int          base_pulses;
    logic [3:0]  k;
    int          r;

    rst = 1'b1;
    key_code = 4'd0;
    key_toggle = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk_all("reset", 32'd0, 4'd0, 2'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed table
    vt.push_back(mk(4'd15, 32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd1,  32'h1,        4'd1, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd2,  32'h12,       4'd2, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd3,  32'h123,      4'd3, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd15, 32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd0,  32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd0,  32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd7,  32'h7,        4'd1, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd15, 32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd4,  32'h4,        4'd1, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd5,  32'h45,       4'd2, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd11, 32'h0,        4'd0, 2'd1, 32'h45, 32'h0, 2'd1, 1'b0, 1'b0));
    vt.push_back(mk(4'd6,  32'h6,        4'd1, 2'd1, 32'h45, 32'h0, 2'd1, 1'b0, 1'b0));
    vt.push_back(mk(4'd14, 32'h6,        4'd1, 2'd2, 32'h45, 32'h6, 2'd1, 1'b0, 1'b1));
    vt.push_back(mk(4'd12, 32'h6,        4'd1, 2'd2, 32'h45, 32'h6, 2'd1, 1'b0, 1'b0));
    vt.push_back(mk(4'd14, 32'h6,        4'd1, 2'd2, 32'h45, 32'h6, 2'd1, 1'b0, 1'b0));
    vt.push_back(mk(4'd9,  32'h9,        4'd1, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd14, 32'h9,        4'd1, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd10, 32'h0,        4'd0, 2'd1, 32'h9,  32'h0, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'd12, 32'h0,        4'd0, 2'd1, 32'h9,  32'h0, 2'd2, 1'b0, 1'b0));
    vt.push_back(mk(4'd13, 32'h0,        4'd0, 2'd1, 32'h9,  32'h0, 2'd3, 1'b0, 1'b0));
    vt.push_back(mk(4'd15, 32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));
    acc = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      acc = {acc[27:0], 4'(i)};
      vt.push_back(mk(4'(i), acc, 4'(i), 2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0));
    end
    vt.push_back(mk(4'd9,  32'h12345678, 4'd8, 2'd0, 32'h0,  32'h0, 2'd0, 1'b1, 1'b0));
    vt.push_back(mk(4'd15, 32'h0,        4'd0, 2'd0, 32'h0,  32'h0, 2'd0, 1'b0, 1'b0));

    for (int i = 0; i < vt.size(); i++) begin
      press(vt[i].key);
      chk_all($sformatf("vec%0d", i), vt[i].entry, vt[i].cnt, vt[i].st, vt[i].a, vt[i].b,
              vt[i].op, vt[i].ovf, vt[i].pulse);
    end
    chk("table.pulses", 32'(pulse_cnt), 32'd1);

    // idle cycles with no toggle edge must hold everything
    press(4'd3);
    repeat (10) @(negedge clk);
    #1;
    chk_all("idle", 32'h3, 4'd1, 2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

    // reset coincident with a pending key event after 2,A
    press(4'd15);
    press(4'd2);
    press(4'd10);
    chk_all("pre_rst", 32'h0, 4'd0, 2'd1, 32'h2, 32'h0, 2'd0, 1'b0, 1'b0);
    base_pulses = pulse_cnt;
    @(negedge clk);
    key_code = 4'd5;
    key_toggle[0] = ~key_toggle[0];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all("rst_evt", 32'h0, 4'd0, 2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    // toggle edge arriving while reset is held is absorbed into history
    @(negedge clk);
    rst = 1'b1;
    key_code = 4'd7;
    key_toggle[0] = ~key_toggle[0];
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all("rst_tog", 32'h0, 4'd0, 2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("rst.pulses", 32'(pulse_cnt), 32'(base_pulses));

    // random key sequences against the reference model
    model_reset();
    m_pulses = pulse_cnt;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 39));
      if (r < 28) k = 4'($urandom_range(0, 9));
      else if (r < 33) k = 4'($urandom_range(10, 13));
      else if (r < 38) k = 4'd14;
      else k = 4'd15;
      press(k);
      model_key(k, ep);
      chk_all($sformatf("rnd%0d", n), to_bcd(m_val), 4'(m_cnt), 2'(m_st), m_a, m_b, 2'(m_op), m_ovf, ep);
      chk($sformatf("rnd%0d.pulses", n), 32'(pulse_cnt), 32'(m_pulses));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
